// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared types, cause codes and mstatus bit positions for the trap controller
package exc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TRAP,
      ST_MRET,
      ST_JUMP
   } state_e;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam int EXC_INST_MISALIGNED = 0;
   localparam int EXC_INST_FAULT      = 1;
   localparam int EXC_ILLEGAL         = 2;
   localparam int EXC_EBREAK          = 3;
   localparam int EXC_ECALL           = 4;
   localparam int EXC_LD_MISALIGNED   = 5;
   localparam int EXC_LD_FAULT        = 6;
   localparam int EXC_ST_MISALIGNED   = 7;
   localparam int EXC_ST_FAULT        = 8;
   localparam int NUM_EXC             = 9;

   localparam int IRQ_SW    = 0;
   localparam int IRQ_TIMER = 1;
   localparam int IRQ_EXT   = 2;

   localparam logic [31:0] CAUSE_INST_MISALIGNED = 32'd0;
   localparam logic [31:0] CAUSE_INST_FAULT      = 32'd1;
   localparam logic [31:0] CAUSE_ILLEGAL         = 32'd2;
   localparam logic [31:0] CAUSE_EBREAK          = 32'd3;
   localparam logic [31:0] CAUSE_LD_MISALIGNED   = 32'd4;
   localparam logic [31:0] CAUSE_LD_FAULT        = 32'd5;
   localparam logic [31:0] CAUSE_ST_MISALIGNED   = 32'd6;
   localparam logic [31:0] CAUSE_ST_FAULT        = 32'd7;
   localparam logic [31:0] CAUSE_ECALL           = 32'd11;
   localparam logic [31:0] CAUSE_IRQ_SW          = 32'h8000_0003;
   localparam logic [31:0] CAUSE_IRQ_TIMER       = 32'h8000_0007;
   localparam logic [31:0] CAUSE_IRQ_EXT         = 32'h8000_000B;

   function automatic logic [31:0] exc_cause(input logic [3:0] idx);
      logic [31:0] c;
      c = 32'd0;
      case (idx)
         4'd0: c = CAUSE_INST_MISALIGNED;
         4'd1: c = CAUSE_INST_FAULT;
         4'd2: c = CAUSE_ILLEGAL;
         4'd3: c = CAUSE_EBREAK;
         4'd4: c = CAUSE_ECALL;
         4'd5: c = CAUSE_LD_MISALIGNED;
         4'd6: c = CAUSE_LD_FAULT;
         4'd7: c = CAUSE_ST_MISALIGNED;
         4'd8: c = CAUSE_ST_FAULT;
         default: c = 32'd0;
      endcase
      return c;
   endfunction

   // Causes whose mtval carries the faulting address.
   function automatic logic mtval_is_addr(input logic [31:0] cause);
      return (cause == CAUSE_INST_MISALIGNED) || (cause == CAUSE_INST_FAULT) ||
             (cause == CAUSE_LD_MISALIGNED)   || (cause == CAUSE_LD_FAULT)   ||
             (cause == CAUSE_ST_MISALIGNED)   || (cause == CAUSE_ST_FAULT);
   endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - picks the winning trap: exceptions (lowest bit first) over interrupts
module exc_prio_enc
   import exc_pkg::*;
(
   input  logic        valid_i,
   input  logic [8:0]  exc_vec_i,
   input  logic [2:0]  irq_i,
   input  logic [2:0]  irq_en_i,
   input  logic        global_ie_i,
   output logic        pending_o,
   output logic        is_irq_o,
   output logic [31:0] cause_o
);

   logic [8:0] exc_act;
   logic [2:0] irq_act;

   always_comb begin
      exc_act   = exc_vec_i & {NUM_EXC{valid_i}};
      // Interrupts are only taken against a retiring instruction so mepc is meaningful.
      irq_act   = irq_i & irq_en_i & {3{global_ie_i & valid_i}};
      pending_o = 1'b0;
      is_irq_o  = 1'b0;
      cause_o   = 32'd0;
      if (|exc_act) begin
         pending_o = 1'b1;
         for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (exc_act[i]) begin
               cause_o = exc_cause(4'(i));
            end
         end
      end else if (|irq_act) begin
         pending_o = 1'b1;
         is_irq_o  = 1'b1;
         if (irq_act[IRQ_EXT]) begin
            cause_o = CAUSE_IRQ_EXT;
         end else if (irq_act[IRQ_SW]) begin
            cause_o = CAUSE_IRQ_SW;
         end else begin
            cause_o = CAUSE_IRQ_TIMER;
         end
      end
   end

endmodule

// File: rtl/exc_unit.sv
// rtl/exc_unit.sv - machine-mode trap/mret controller feeding the CSR exception write port
// Optional EXC_VECTORED_EN: vectored interrupt targets when mtvec[1:0] == 2'b01.
module exc_unit
   import exc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] mem_addr_i,
   input  logic [8:0]  exc_vec_i,
   input  logic        mret_i,
   input  logic [2:0]  irq_i,
   input  logic [31:0] mstatus_i,
   input  logic [31:0] mie_i,
   input  logic [31:0] mtvec_i,
   input  logic [31:0] mepc_i,
   output logic        we_exc_o,
   output logic [31:0] mcause_o,
   output logic [31:0] mepc_o,
   output logic [31:0] mtval_o,
   output logic [31:0] mstatus_o,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o,
   output logic        flush_o,
   output logic        busy_o
);

   state_e      state_q, state_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mtval_q, mtval_d;
   logic [31:0] mstatus_q, mstatus_d;
   logic        is_irq_q, is_irq_d;
   logic        is_mret_q, is_mret_d;

   logic        pending;
   logic        is_irq;
   logic [31:0] cause;
   logic [31:0] trap_mstatus;
   logic [31:0] mret_mstatus;
   logic [31:0] trap_target;
   logic        unused_bits;

   exc_prio_enc u_prio (
      .valid_i     (valid_i),
      .exc_vec_i   (exc_vec_i),
      .irq_i       (irq_i),
      .irq_en_i    ({mie_i[11], mie_i[7], mie_i[3]}),
      .global_ie_i (mstatus_i[MSTATUS_MIE]),
      .pending_o   (pending),
      .is_irq_o    (is_irq),
      .cause_o     (cause)
   );

   always_comb begin
      trap_mstatus = mstatus_i;
      trap_mstatus[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
      trap_mstatus[MSTATUS_MIE]  = 1'b0;
      trap_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

      mret_mstatus = mstatus_i;
      mret_mstatus[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
      mret_mstatus[MSTATUS_MPIE] = 1'b1;
      mret_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
   end

   always_comb begin
      state_d   = state_q;
      mcause_d  = mcause_q;
      mepc_d    = mepc_q;
      mtval_d   = mtval_q;
      mstatus_d = mstatus_q;
      is_irq_d  = is_irq_q;
      is_mret_d = is_mret_q;
      case (state_q)
         ST_IDLE: begin
            if (pending) begin
               state_d   = ST_TRAP;
               mcause_d  = cause;
               mepc_d    = pc_i;
               mstatus_d = trap_mstatus;
               is_irq_d  = is_irq;
               is_mret_d = 1'b0;
               if (is_irq) begin
                  mtval_d = 32'd0;
               end else if (cause == CAUSE_ILLEGAL) begin
                  mtval_d = instr_i;
               end else if (mtval_is_addr(cause)) begin
                  mtval_d = mem_addr_i;
               end else begin
                  mtval_d = 32'd0;
               end
            end else if (valid_i && mret_i) begin
               // mcause/mtval keep the last trap's values so the CSR write is a no-op for them.
               state_d   = ST_MRET;
               mepc_d    = mepc_i;
               mstatus_d = mret_mstatus;
               is_irq_d  = 1'b0;
               is_mret_d = 1'b1;
            end
         end
         ST_TRAP: state_d = ST_JUMP;
         ST_MRET: state_d = ST_JUMP;
         ST_JUMP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      trap_target = {mtvec_i[31:2], 2'b00};
`ifdef EXC_VECTORED_EN
      if (is_irq_q && (mtvec_i[1:0] == 2'b01)) begin
         trap_target = {mtvec_i[31:2], 2'b00} + {25'd0, mcause_q[4:0], 2'b00};
      end
`else
      trap_target = {mtvec_i[31:2], 2'b00};
`endif
   end

   always_comb begin
      we_exc_o      = 1'b0;
      flush_o       = 1'b0;
      mcause_o      = 32'd0;
      mepc_o        = 32'd0;
      mtval_o       = 32'd0;
      mstatus_o     = 32'd0;
      redirect_o    = 1'b0;
      redirect_pc_o = 32'd0;
      busy_o        = 1'b0;
      if (rst_i) begin
         redirect_pc_o = RESET_PC;
      end else begin
         busy_o = (state_q != ST_IDLE);
         if ((state_q == ST_TRAP) || (state_q == ST_MRET)) begin
            we_exc_o  = 1'b1;
            flush_o   = 1'b1;
            mcause_o  = mcause_q;
            mepc_o    = mepc_q;
            mtval_o   = mtval_q;
            mstatus_o = mstatus_q;
         end
         if (state_q == ST_JUMP) begin
            redirect_o    = 1'b1;
            redirect_pc_o = is_mret_q ? {mepc_i[31:2], 2'b00} : trap_target;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         mcause_q  <= 32'd0;
         mepc_q    <= 32'd0;
         mtval_q   <= 32'd0;
         mstatus_q <= 32'd0;
         is_irq_q  <= 1'b0;
         is_mret_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcause_q  <= mcause_d;
         mepc_q    <= mepc_d;
         mtval_q   <= mtval_d;
         mstatus_q <= mstatus_d;
         is_irq_q  <= is_irq_d;
         is_mret_q <= is_mret_d;
      end
   end

   assign unused_bits = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0],
                          mtvec_i[1:0], mepc_i[1:0], is_irq_q};

endmodule

// File: tb/tb_exc_unit.sv
// tb/tb_exc_unit.sv - scoreboard bench for exc_unit with directed trap/mret/irq vectors
module tb_exc_unit;

   typedef struct packed {
      logic [31:0] mcause;
      logic [31:0] mepc;
      logic [31:0] mtval;
      logic [31:0] mstatus;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [31:0] pc, instr, mem_addr;
   logic [8:0]  exc_vec;
   logic        mret;
   logic [2:0]  irq;
   logic [31:0] mstatus, mie, mtvec, mepc;
   logic        we_exc_o, redirect_o, flush_o, busy_o;
   logic [31:0] mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o;

   wr_t         wr_q[$];
   logic [31:0] rd_q[$];
   wr_t         e;
   logic [31:0] er;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          busy_cnt;

   exc_unit dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .valid_i       (valid),
      .pc_i          (pc),
      .instr_i       (instr),
      .mem_addr_i    (mem_addr),
      .exc_vec_i     (exc_vec),
      .mret_i        (mret),
      .irq_i         (irq),
      .mstatus_i     (mstatus),
      .mie_i         (mie),
      .mtvec_i       (mtvec),
      .mepc_i        (mepc),
      .we_exc_o      (we_exc_o),
      .mcause_o      (mcause_o),
      .mepc_o        (mepc_o),
      .mtval_o       (mtval_o),
      .mstatus_o     (mstatus_o),
      .redirect_o    (redirect_o),
      .redirect_pc_o (redirect_pc_o),
      .flush_o       (flush_o),
      .busy_o        (busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (we_exc_o) begin
         if (wr_q.size() == 0) begin
            check("unexpected_we_exc", 32'(we_exc_o), 32'd0);
         end else begin
            e = wr_q.pop_front();
            check("mcause", mcause_o, e.mcause);
            check("mepc", mepc_o, e.mepc);
            check("mtval", mtval_o, e.mtval);
            check("mstatus", mstatus_o, e.mstatus);
            check("flush", 32'(flush_o), 32'd1);
         end
      end
      if (redirect_o) begin
         if (rd_q.size() == 0) begin
            check("unexpected_redirect", 32'(redirect_o), 32'd0);
         end else begin
            er = rd_q.pop_front();
            check("redirect_pc", redirect_pc_o, er);
         end
      end
   end

   task automatic expect_txn(input logic [31:0] c, input logic [31:0] ep, input logic [31:0] tv,
                             input logic [31:0] ms, input logic [31:0] rpc);
      wr_t w;
      w.mcause  = c;
      w.mepc    = ep;
      w.mtval   = tv;
      w.mstatus = ms;
      wr_q.push_back(w);
      rd_q.push_back(rpc);
   endtask

   // Inputs are held through the whole transaction; optionally drop irq after capture.
   task automatic go(input bit drop_irq);
      @(posedge clk);
      #1;
      if (drop_irq) irq = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      valid = 1'b0; exc_vec = 9'd0; mret = 1'b0; irq = 3'b000;
      @(posedge clk);
      #1;
      check("wr_drained", 32'(wr_q.size()), 32'd0);
      check("rd_drained", 32'(rd_q.size()), 32'd0);
      wr_q.delete();
      rd_q.delete();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_we"}, 32'(we_exc_o), 32'd0);
      check({tag, "_busy"}, 32'(busy_o), 32'd0);
      check({tag, "_redir"}, 32'(redirect_o), 32'd0);
      check({tag, "_flush"}, 32'(flush_o), 32'd0);
      check({tag, "_data"}, mcause_o | mepc_o | mtval_o | mstatus_o | redirect_pc_o, 32'd0);
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; pc = 32'd0; instr = 32'd0; mem_addr = 32'd0;
      exc_vec = 9'd0; mret = 1'b0; irq = 3'b000;
      mstatus = 32'd0; mie = 32'd0; mtvec = 32'd0; mepc = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk);
      #1;

      // Illegal instruction
      valid = 1'b1; exc_vec = 9'h004; pc = 32'h100; instr = 32'hFFFF_FFFF;
      mem_addr = 32'hDEAD_0000; mtvec = 32'h200; mstatus = 32'h8;
      expect_txn(32'd2, 32'h100, 32'hFFFF_FFFF, 32'h1880, 32'h200);
      go(1'b0);

      // mret: mcause/mtval echo the last trap's values
      valid = 1'b1; mret = 1'b1; mstatus = 32'h1880; mepc = 32'h104;
      expect_txn(32'd2, 32'h104, 32'hFFFF_FFFF, 32'h1888, 32'h104);
      go(1'b0);

      // Exceptions beat interrupts; ld_misaligned beats ld_fault
      valid = 1'b1; exc_vec = 9'h060; irq = 3'b111; mie = 32'h888; mstatus = 32'h8;
      pc = 32'h300; mem_addr = 32'h1234_5678; mtvec = 32'h200;
      expect_txn(32'd4, 32'h300, 32'h1234_5678, 32'h1880, 32'h200);
      go(1'b0);

      // Timer interrupt, dropped after capture
      valid = 1'b1; irq = 3'b010; mie = 32'h80; mstatus = 32'h8; mtvec = 32'h201; pc = 32'h40;
`ifdef EXC_VECTORED_EN
      expect_txn(32'h8000_0007, 32'h40, 32'd0, 32'h1880, 32'h21C);
`else
      expect_txn(32'h8000_0007, 32'h40, 32'd0, 32'h1880, 32'h200);
`endif
      go(1'b1);

      // External beats all
      valid = 1'b1; irq = 3'b111; mie = 32'h888; mstatus = 32'h8; mtvec = 32'h301; pc = 32'h80;
`ifdef EXC_VECTORED_EN
      expect_txn(32'h8000_000B, 32'h80, 32'd0, 32'h1880, 32'h32C);
`else
      expect_txn(32'h8000_000B, 32'h80, 32'd0, 32'h1880, 32'h300);
`endif
      go(1'b0);

      // Software beats timer
      valid = 1'b1; irq = 3'b011; pc = 32'h84;
`ifdef EXC_VECTORED_EN
      expect_txn(32'h8000_0003, 32'h84, 32'd0, 32'h1880, 32'h30C);
`else
      expect_txn(32'h8000_0003, 32'h84, 32'd0, 32'h1880, 32'h300);
`endif
      go(1'b0);

      // Exception with mret: exception wins
      valid = 1'b1; exc_vec = 9'h080; mret = 1'b1; mem_addr = 32'hABC; mtvec = 32'h400;
      mstatus = 32'h1888; pc = 32'h90; mepc = 32'h777;
      expect_txn(32'd6, 32'h90, 32'hABC, 32'h1880, 32'h400);
      go(1'b0);

      // Bit 0 beats bit 8; exceptions ignore vectored mode
      valid = 1'b1; exc_vec = 9'h101; mem_addr = 32'h55; mtvec = 32'h401; mstatus = 32'h8; pc = 32'hA0;
      expect_txn(32'd0, 32'hA0, 32'h55, 32'h1880, 32'h400);
      go(1'b0);

      // ebreak: mtval 0, MPIE from cleared MIE
      valid = 1'b1; exc_vec = 9'h008; mstatus = 32'h0; pc = 32'hB0; mtvec = 32'h500;
      expect_txn(32'd3, 32'hB0, 32'd0, 32'h1800, 32'h500);
      go(1'b0);

      // Globally masked interrupts
      valid = 1'b1; irq = 3'b111; mie = 32'h888; mstatus = 32'h0;
      busy_cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (busy_o) busy_cnt++;
      end
      check("masked_busy", 32'(busy_cnt), 32'd0);

      // Enabled interrupt without a retiring instruction
      valid = 1'b0; mstatus = 32'h8;
      busy_cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (busy_o) busy_cnt++;
      end
      check("novalid_busy", 32'(busy_cnt), 32'd0);
      @(posedge clk);
      #1;
      irq = 3'b000;

      // Reset in N+1 of an ecall
      valid = 1'b1; exc_vec = 9'h010; pc = 32'h500; mtvec = 32'h600;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; valid = 1'b0; exc_vec = 9'd0;
      @(negedge clk);
      check_idle_outputs("post_rst");
      @(posedge clk);
      #1;
      valid = 1'b1; exc_vec = 9'h008; mstatus = 32'h8; pc = 32'h504;
      expect_txn(32'd3, 32'h504, 32'd0, 32'h1880, 32'h600);
      go(1'b0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
